// File: rtl/huffman_decoder.sv
// Bit-serial decoder for the fixed prefix-free code {0,10,1100,1101+5b literal}; 111 is an invalid prefix.
// Optional feature macro HUF_ERR_OUT_EN adds the err_out strobe for invalid prefixes.
module huffman_decoder #(
    parameter int SYM_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    output logic [SYM_W-1:0] symbol_out,
    output logic             valid_out,
`ifdef HUF_ERR_OUT_EN
    output logic             err_out,
`endif
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        ROOT = 3'd0,
        S1   = 3'd1,
        S11  = 3'd2,
        S110 = 3'd3,
        ESC  = 3'd4
    } state_t;

    state_t           state;
    logic [2:0]       cnt;
    logic [SYM_W-1:0] lit;

    assign state_dbg = state;

    // Handshake: valid_out is a one-cycle strobe with no ready; the consumer must take
    // symbol_out in the cycle valid_out is high. symbol_out holds between strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ROOT;
            cnt        <= '0;
            lit        <= '0;
            symbol_out <= '0;
            valid_out  <= 1'b0;
`ifdef HUF_ERR_OUT_EN
            err_out    <= 1'b0;
`endif
        end else begin
            valid_out <= 1'b0;
`ifdef HUF_ERR_OUT_EN
            err_out   <= 1'b0;
`endif
            case (state)
                ROOT: begin
                    if (bit_in) begin
                        state <= S1;
                    end else begin
                        symbol_out <= SYM_W'(1);
                        valid_out  <= 1'b1;
                    end
                end
                S1: begin
                    if (bit_in) begin
                        state <= S11;
                    end else begin
                        symbol_out <= SYM_W'(2);
                        valid_out  <= 1'b1;
                        state      <= ROOT;
                    end
                end
                S11: begin
                    if (bit_in) begin
                        // Invalid prefix 111: drop it and decode the next bit from ROOT.
`ifdef HUF_ERR_OUT_EN
                        err_out <= 1'b1;
`endif
                        state <= ROOT;
                    end else begin
                        state <= S110;
                    end
                end
                S110: begin
                    if (bit_in) begin
                        cnt   <= '0;
                        lit   <= '0;
                        state <= ESC;
                    end else begin
                        symbol_out <= SYM_W'(3);
                        valid_out  <= 1'b1;
                        state      <= ROOT;
                    end
                end
                ESC: begin
                    lit <= {lit[SYM_W-2:0], bit_in};
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'(SYM_W - 1)) begin
                        symbol_out <= {lit[SYM_W-2:0], bit_in};
                        valid_out  <= 1'b1;
                        cnt        <= '0;
                        state      <= ROOT;
                    end
                end
                default: state <= ROOT;
            endcase
        end
    end

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed-vector bench for huffman_decoder; builds with or without HUF_ERR_OUT_EN.
module tb_huffman_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       bit_in = 1'b0;
    logic [4:0] symbol_out;
    logic       valid_out;
    logic [2:0] state_dbg;
`ifdef HUF_ERR_OUT_EN
    logic       err_out;
`endif

    int errors = 0;
    int checks = 0;

    huffman_decoder #(.SYM_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .symbol_out (symbol_out),
        .valid_out  (valid_out),
`ifdef HUF_ERR_OUT_EN
        .err_out    (err_out),
`endif
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    // Present one bit before the next rising edge, then sample 1 time unit after it.
    task automatic drive_bit(input logic b);
        bit_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        checks++;
        if (symbol_out !== 5'd0) begin errors++; $display("FAIL reset_symbol: got %0d want 0", symbol_out); end
        checks++;
        if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
`ifdef HUF_ERR_OUT_EN
        checks++;
        if (err_out !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_out); end
`endif
        rst = 1'b1;
    endtask

    task automatic test_zeros();
        for (int i = 0; i < 8; i++) begin
            drive_bit(1'b0);
            checks++;
            if (valid_out !== 1'b1 || symbol_out !== 5'd1) begin
                errors++;
                $display("FAIL zeros[%0d]: got v=%b s=%0d want v=1 s=1", i, valid_out, symbol_out);
            end
        end
    endtask

    task automatic test_sym2();
        logic [7:0] stream;
        logic [7:0] exp_v;
        int pulses;
        stream = 8'b00000010;
        exp_v  = 8'b11111101;
        pulses = 0;
        for (int i = 7; i >= 0; i--) begin
            drive_bit(stream[i]);
            if (valid_out === 1'b1) pulses++;
            checks++;
            if (valid_out !== exp_v[i]) begin
                errors++;
                $display("FAIL sym2_valid[%0d]: got %b want %b", 7 - i, valid_out, exp_v[i]);
            end
        end
        checks++;
        if (symbol_out !== 5'd2) begin errors++; $display("FAIL sym2_symbol: got %0d want 2", symbol_out); end
        checks++;
        if (pulses != 7) begin errors++; $display("FAIL sym2_pulses: got %0d want 7", pulses); end
    endtask

    task automatic test_invalid();
        logic [8:0] stream;
        logic [8:0] exp_v;
        logic [8:0] exp_e;
        int err_pulses;
        stream = 9'b000001110;
        exp_v  = 9'b111110001;
        exp_e  = 9'b000000010;
        err_pulses = 0;
        for (int i = 8; i >= 0; i--) begin
            drive_bit(stream[i]);
            checks++;
            if (valid_out !== exp_v[i] || symbol_out !== 5'd1) begin
                errors++;
                $display("FAIL invalid[%0d]: got v=%b s=%0d want v=%b s=1", 8 - i, valid_out, symbol_out, exp_v[i]);
            end
`ifdef HUF_ERR_OUT_EN
            if (err_out === 1'b1) err_pulses++;
            checks++;
            if (err_out !== exp_e[i]) begin
                errors++;
                $display("FAIL invalid_err[%0d]: got %b want %b", 8 - i, err_out, exp_e[i]);
            end
`endif
        end
`ifdef HUF_ERR_OUT_EN
        checks++;
        if (err_pulses != 1) begin errors++; $display("FAIL invalid_err_pulses: got %0d want 1", err_pulses); end
`endif
    endtask

    task automatic test_escape();
        logic [12:0] stream;
        logic [12:0] exp_v;
        stream = 13'b1100_1101_10110;
        exp_v  = 13'b0001_0000_00001;
        for (int i = 12; i >= 0; i--) begin
            drive_bit(stream[i]);
            checks++;
            if (valid_out !== exp_v[i]) begin
                errors++;
                $display("FAIL escape_valid[%0d]: got %b want %b", 12 - i, valid_out, exp_v[i]);
            end
            if (i == 9) begin
                checks++;
                if (symbol_out !== 5'd3) begin errors++; $display("FAIL escape_sym3: got %0d want 3", symbol_out); end
            end
        end
        checks++;
        if (symbol_out !== 5'd22) begin errors++; $display("FAIL escape_sym22: got %0d want 22", symbol_out); end
    endtask

    // Literal bounds 0 and 31, each followed immediately by a 0 codeword.
    task automatic test_back_to_back();
        logic [4:0] lits [2];
        lits[0] = 5'd0;
        lits[1] = 5'd31;
        for (int k = 0; k < 2; k++) begin
            drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
            for (int j = 4; j >= 0; j--) drive_bit(lits[k][j]);
            checks++;
            if (valid_out !== 1'b1 || symbol_out !== lits[k]) begin
                errors++;
                $display("FAIL b2b_lit%0d: got v=%b s=%0d want v=1 s=%0d", k, valid_out, symbol_out, lits[k]);
            end
            drive_bit(1'b0);
            checks++;
            if (valid_out !== 1'b1 || symbol_out !== 5'd1) begin
                errors++;
                $display("FAIL b2b_next%0d: got v=%b s=%0d want v=1 s=1", k, valid_out, symbol_out);
            end
        end
    endtask

    task automatic test_reset_mid_escape();
        logic [5:0] stream;
        stream = 6'b110110;
        for (int i = 5; i >= 0; i--) drive_bit(stream[i]);
        checks++;
        if (state_dbg !== 3'd4) begin errors++; $display("FAIL mid_esc_state: got %0d want 4", state_dbg); end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (symbol_out !== 5'd0 || valid_out !== 1'b0 || state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: got s=%0d v=%b st=%0d want 0 0 0", symbol_out, valid_out, state_dbg);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        drive_bit(1'b1);
        checks++;
        if (valid_out !== 1'b0 || symbol_out !== 5'd0) begin
            errors++;
            $display("FAIL post_reset_1: got v=%b s=%0d want v=0 s=0", valid_out, symbol_out);
        end
        drive_bit(1'b0);
        checks++;
        if (valid_out !== 1'b1 || symbol_out !== 5'd2) begin
            errors++;
            $display("FAIL post_reset_sym2: got v=%b s=%0d want v=1 s=2", valid_out, symbol_out);
        end
    endtask

    task automatic test_idle_s110();
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        checks++;
        if (valid_out !== 1'b0 || state_dbg !== 3'd3 || symbol_out !== 5'd2) begin
            errors++;
            $display("FAIL idle_s110: got v=%b st=%0d s=%0d want v=0 st=3 s=2", valid_out, state_dbg, symbol_out);
        end
        drive_bit(1'b0);
        checks++;
        if (valid_out !== 1'b1 || symbol_out !== 5'd3) begin
            errors++;
            $display("FAIL idle_sym3: got v=%b s=%0d want v=1 s=3", valid_out, symbol_out);
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_zeros();
        test_sym2();
        test_invalid();
        test_escape();
        test_back_to_back();
        test_reset_mid_escape();
        test_idle_s110();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
